// File: rtl/main_net_param_loader.sv
// main_net_param_loader: streams all layer weights from a synchronous weight RAM into main_net,
// then raises load-weight-done and streams one captured input state vector.
module main_net_param_loader #(
  parameter int DATA_WIDTH                    = 32,
  parameter int LAYER_WIDTH                   = 2,
  parameter int NUMBER_OF_INPUT_NODE          = 2,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_1 = 24,
  parameter int NUMBER_OF_HIDDEN_NODE_LAYER_2 = 24,
  parameter int NUMBER_OF_OUTPUT_NODE         = 3,
  parameter int WEIGHT_COUNTER_WIDTH          = 11,
  parameter int DATA_COUNTER_WIDTH            = $clog2(NUMBER_OF_HIDDEN_NODE_LAYER_1)
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         i_start,
  input  logic [NUMBER_OF_INPUT_NODE*DATA_WIDTH-1:0]   i_state,
  output logic                                         o_busy,
  output logic                                         o_mem_rd_en,
  output logic [LAYER_WIDTH-1:0]                       o_mem_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]              o_mem_addr,
  input  logic [DATA_WIDTH-1:0]                        i_mem_data,
  output logic                                         o_weight_valid,
  output logic [LAYER_WIDTH-1:0]                       o_weight_layer,
  output logic [WEIGHT_COUNTER_WIDTH-1:0]              o_weight_addr,
  output logic [DATA_WIDTH-1:0]                        o_weight,
  output logic                                         o_load_weight_done,
  output logic                                         o_data_valid,
  output logic [DATA_COUNTER_WIDTH-1:0]                o_data_addr,
  output logic [DATA_WIDTH-1:0]                        o_data
);
  localparam int DW = DATA_WIDTH;
  localparam int LW = LAYER_WIDTH;
  localparam int WW = WEIGHT_COUNTER_WIDTH;
  localparam int CW = DATA_COUNTER_WIDTH;
  localparam int IN = NUMBER_OF_INPUT_NODE;
  localparam int H1 = NUMBER_OF_HIDDEN_NODE_LAYER_1;
  localparam int H2 = NUMBER_OF_HIDDEN_NODE_LAYER_2;
  localparam int OT = NUMBER_OF_OUTPUT_NODE;
  localparam logic [WW-1:0] LAST1 = WW'(H1 * (IN + 1) - 1);
  localparam logic [WW-1:0] LAST2 = WW'(H2 * (H1 + 1) - 1);
  localparam logic [WW-1:0] LAST3 = WW'(OT * (H2 + 1) - 1);

  typedef enum logic [2:0] {IDLE, RD_L1, RD_L2, RD_L3, DRAIN, DATA} state_t;

  state_t          state_q, state_d;
  logic [IN*DW-1:0] cap_q, cap_d;
  logic            busy_q, busy_d;
  logic            rd_en_q, rd_en_d;
  logic [LW-1:0]   mem_layer_q, mem_layer_d;
  logic [WW-1:0]   mem_addr_q, mem_addr_d;
  logic            p_valid_q, p_valid_d;
  logic [LW-1:0]   p_layer_q, p_layer_d;
  logic [WW-1:0]   p_addr_q, p_addr_d;
  logic            w_valid_q, w_valid_d;
  logic [LW-1:0]   w_layer_q, w_layer_d;
  logic [WW-1:0]   w_addr_q, w_addr_d;
  logic [DW-1:0]   w_q, w_d;
  logic            done_q, done_d;
  logic            d_valid_q, d_valid_d;
  logic [CW-1:0]   d_addr_q, d_addr_d;
  logic [DW-1:0]   d_q, d_d;
  logic [WW-1:0]   last;
  logic [CW-1:0]   d_sel;
  logic            d_load;

  always_comb begin
    state_d     = state_q;
    cap_d       = cap_q;
    busy_d      = busy_q;
    rd_en_d     = 1'b0;
    mem_layer_d = mem_layer_q;
    mem_addr_d  = mem_addr_q;
    p_valid_d   = rd_en_q;
    p_layer_d   = mem_layer_q;
    p_addr_d    = mem_addr_q;
    w_valid_d   = p_valid_q;
    w_layer_d   = p_valid_q ? p_layer_q : w_layer_q;
    w_addr_d    = p_valid_q ? p_addr_q : w_addr_q;
    w_d         = p_valid_q ? i_mem_data : w_q;
    done_d      = done_q;
    d_valid_d   = 1'b0;
    d_addr_d    = d_addr_q;
    d_sel       = d_addr_q + CW'(1);
    d_load      = 1'b0;
    last        = state_q == RD_L1 ? LAST1 : state_q == RD_L2 ? LAST2 : LAST3;
    case (state_q)
      IDLE: if (i_start) begin
        state_d     = RD_L1;
        cap_d       = i_state;
        done_d      = 1'b0;
        busy_d      = 1'b1;
        rd_en_d     = 1'b1;
        mem_layer_d = LW'(1);
        mem_addr_d  = '0;
      end
      RD_L1, RD_L2, RD_L3: begin
        rd_en_d = 1'b1;
        if (mem_addr_q != last) mem_addr_d = mem_addr_q + WW'(1);
        else if (state_q == RD_L3) begin
          state_d = DRAIN;
          rd_en_d = 1'b0;
        end else begin
          state_d     = state_q == RD_L1 ? RD_L2 : RD_L3;
          mem_layer_d = mem_layer_q + LW'(1);
          mem_addr_d  = '0;
        end
      end
      // The final weight beat is on the output while nothing is left in the RAM stage.
      DRAIN: if (w_valid_q && !p_valid_q) begin
        state_d   = DATA;
        done_d    = 1'b1;
        d_valid_d = 1'b1;
        d_addr_d  = '0;
        d_sel     = '0;
        d_load    = 1'b1;
      end
      DATA: if (d_addr_q == CW'(IN - 1)) begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end else begin
        d_valid_d = 1'b1;
        d_addr_d  = d_sel;
        d_load    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    d_d = d_q;
    for (int k = 0; k < IN; k++)
      if (d_load && d_sel == CW'(k)) d_d = cap_q[k*DW +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cap_q       <= '0;
      busy_q      <= 1'b0;
      rd_en_q     <= 1'b0;
      mem_layer_q <= '0;
      mem_addr_q  <= '0;
      p_valid_q   <= 1'b0;
      p_layer_q   <= '0;
      p_addr_q    <= '0;
      w_valid_q   <= 1'b0;
      w_layer_q   <= '0;
      w_addr_q    <= '0;
      w_q         <= '0;
      done_q      <= 1'b0;
      d_valid_q   <= 1'b0;
      d_addr_q    <= '0;
      d_q         <= '0;
    end else begin
      state_q     <= state_d;
      cap_q       <= cap_d;
      busy_q      <= busy_d;
      rd_en_q     <= rd_en_d;
      mem_layer_q <= mem_layer_d;
      mem_addr_q  <= mem_addr_d;
      p_valid_q   <= p_valid_d;
      p_layer_q   <= p_layer_d;
      p_addr_q    <= p_addr_d;
      w_valid_q   <= w_valid_d;
      w_layer_q   <= w_layer_d;
      w_addr_q    <= w_addr_d;
      w_q         <= w_d;
      done_q      <= done_d;
      d_valid_q   <= d_valid_d;
      d_addr_q    <= d_addr_d;
      d_q         <= d_d;
    end
  end

  assign o_busy             = busy_q;
  assign o_mem_rd_en        = rd_en_q;
  assign o_mem_layer        = mem_layer_q;
  assign o_mem_addr         = mem_addr_q;
  assign o_weight_valid     = w_valid_q;
  assign o_weight_layer     = w_layer_q;
  assign o_weight_addr      = w_addr_q;
  assign o_weight           = w_q;
  assign o_load_weight_done = done_q;
  assign o_data_valid       = d_valid_q;
  assign o_data_addr        = d_addr_q;
  assign o_data             = d_q;
endmodule

// File: tb/tb_main_net_param_loader.sv
// tb_main_net_param_loader: scoreboard bench for the default loader and a tiny-parameter instance.
module tb_main_net_param_loader;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic a_start, a_busy, a_rd, a_wv, a_done, a_dv;
  logic [63:0] a_state;
  logic [1:0] a_ml, a_wl;
  logic [10:0] a_ma, a_wa;
  logic [31:0] a_md, a_w, a_d;
  logic [4:0] a_da;
  logic b_start, b_busy, b_rd, b_wv, b_done, b_dv;
  logic [31:0] b_state;
  logic [1:0] b_ml, b_wl;
  logic [10:0] b_ma, b_wa;
  logic [31:0] b_md, b_w, b_d;
  logic [0:0] b_da;

  main_net_param_loader dut_a (
    .clk(clk), .rst_n(rst_n), .i_start(a_start), .i_state(a_state), .o_busy(a_busy),
    .o_mem_rd_en(a_rd), .o_mem_layer(a_ml), .o_mem_addr(a_ma), .i_mem_data(a_md),
    .o_weight_valid(a_wv), .o_weight_layer(a_wl), .o_weight_addr(a_wa), .o_weight(a_w),
    .o_load_weight_done(a_done), .o_data_valid(a_dv), .o_data_addr(a_da), .o_data(a_d));

  main_net_param_loader #(
    .NUMBER_OF_INPUT_NODE(1), .NUMBER_OF_HIDDEN_NODE_LAYER_1(2),
    .NUMBER_OF_HIDDEN_NODE_LAYER_2(2), .NUMBER_OF_OUTPUT_NODE(1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .i_start(b_start), .i_state(b_state), .o_busy(b_busy),
    .o_mem_rd_en(b_rd), .o_mem_layer(b_ml), .o_mem_addr(b_ma), .i_mem_data(b_md),
    .o_weight_valid(b_wv), .o_weight_layer(b_wl), .o_weight_addr(b_wa), .o_weight(b_w),
    .o_load_weight_done(b_done), .o_data_valid(b_dv), .o_data_addr(b_da), .o_data(b_d));

  // Weight RAMs hold {layer,addr}; a read-less cycle returns a poison word.
  always @(posedge clk) a_md <= a_rd ? 32'({a_ml, a_ma}) : 32'hDEADBEEF;
  always @(posedge clk) b_md <= b_rd ? 32'({b_ml, b_ma}) : 32'hDEADBEEF;

  typedef struct packed {
    logic        dat;
    logic [1:0]  l;
    logic [10:0] a;
    logic [31:0] d;
    logic        first;
  } beat_t;

  beat_t qa[$];
  beat_t qb[$];
  int n_cmp = 0, n_bad = 0, sa = 0, sb = 0;
  bit pa = 0, pb = 0;

  function automatic void check(input string tag, input bit ok, input string msg);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: %s", tag, msg);
    end
  endfunction

  function automatic void beat(input string tag, input beat_t e, input logic dv, input logic wv,
                               input logic [1:0] wl, input logic [10:0] wa, input logic [31:0] w,
                               input logic [10:0] da, input logic [31:0] d, input logic done,
                               input bit prev, input int lat);
    bit ok;
    if (e.dat) ok = dv && !wv && da == e.a && d == e.d && done;
    else ok = wv && !dv && wl == e.l && wa == e.a && w == e.d && !done;
    ok = ok && (e.first ? lat == 3 : prev);
    check(tag, ok, $sformatf("got dv=%0b wv=%0b l=%0h a=%0h w=%h da=%0h d=%h done=%0b prev=%0b lat=%0d, want dat=%0b l=%0h a=%0h d=%h first=%0b",
          dv, wv, wl, wa, w, da, d, done, prev, lat, e.dat, e.l, e.a, e.d, e.first));
  endfunction

  always @(negedge clk) begin
    if (!rst_n) pa = 0;
    else begin
      if (a_wv || a_dv) begin
        if (qa.size() == 0) check("a_extra", 0, $sformatf("got wv=%0b dv=%0b, want no beat", a_wv, a_dv));
        else beat("a_beat", qa.pop_front(), a_dv, a_wv, a_wl, a_wa, a_w, 11'(a_da), a_d, a_done, pa, cyc - sa);
      end
      pa = a_wv || a_dv;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) pb = 0;
    else begin
      if (b_wv || b_dv) begin
        if (qb.size() == 0) check("b_extra", 0, $sformatf("got wv=%0b dv=%0b, want no beat", b_wv, b_dv));
        else beat("b_beat", qb.pop_front(), b_dv, b_wv, b_wl, b_wa, b_w, 11'(b_da), b_d, b_done, pb, cyc - sb);
      end
      pb = b_wv || b_dv;
    end
  end

  task automatic push_exp(input bit w, input logic [63:0] st);
    int in, h1, h2, o;
    int n[3];
    beat_t e;
    bit f;
    in = w ? 1 : 2;
    h1 = w ? 2 : 24;
    h2 = w ? 2 : 24;
    o  = w ? 1 : 3;
    n[0] = h1 * (in + 1);
    n[1] = h2 * (h1 + 1);
    n[2] = o * (h2 + 1);
    f = 1;
    for (int l = 0; l < 3; l++)
      for (int a = 0; a < n[l]; a++) begin
        e.dat = 0; e.l = 2'(l + 1); e.a = 11'(a); e.d = 32'({2'(l + 1), 11'(a)}); e.first = f;
        f = 0;
        if (w) qb.push_back(e); else qa.push_back(e);
      end
    for (int k = 0; k < in; k++) begin
      e.dat = 1; e.l = 0; e.a = 11'(k); e.d = st[k*32 +: 32]; e.first = 0;
      if (w) qb.push_back(e); else qa.push_back(e);
    end
  endtask

  task automatic pulse(input bit w, input logic [63:0] st);
    @(posedge clk);
    #1;
    if (w) begin b_state = st[31:0]; b_start = 1; end
    else begin a_state = st; a_start = 1; end
    @(posedge clk);
    if (w) sb = cyc; else sa = cyc;
    #1;
    a_start = 0;
    b_start = 0;
    check("start_ack", w ? (b_busy && !b_done) : (a_busy && !a_done),
          $sformatf("busy=%0b done=%0b, want busy=1 done=0", w ? b_busy : a_busy, w ? b_done : a_done));
  endtask

  task automatic finish_run(input bit w);
    for (int i = 0; i < 3000 && (w ? b_busy : a_busy); i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    check("end_state", w ? (!b_busy && b_done && qb.size() == 0) : (!a_busy && a_done && qa.size() == 0),
          $sformatf("busy=%0b done=%0b pending=%0d, want busy=0 done=1 pending=0",
                    w ? b_busy : a_busy, w ? b_done : a_done, w ? qb.size() : qa.size()));
  endtask

  function automatic bit a_zero();
    return {a_busy, a_rd, a_ml, a_ma, a_wv, a_wl, a_wa, a_w, a_done, a_dv, a_da, a_d} == '0;
  endfunction

  localparam logic [63:0] ST1 = 64'h3B84707D_BEF283C2;
  localparam logic [63:0] ST2 = 64'hC0490FDB_3F800000;

  initial begin
    a_start = 0; b_start = 0; a_state = '0; b_state = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold", a_zero() && !b_busy && !b_done, "outputs not all zero in reset");
    rst_n = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_quiet", a_zero(), $sformatf("busy=%0b rd=%0b wv=%0b dv=%0b done=%0b, want all 0", a_busy, a_rd, a_wv, a_dv, a_done));
    end
    push_exp(0, ST1);
    pulse(0, ST1);
    finish_run(0);
    push_exp(0, ST2);
    pulse(0, ST2);
    repeat (100) @(posedge clk);
    #1;
    a_start = 1;
    a_state = ~ST2;
    @(posedge clk);
    #1;
    a_start = 0;
    finish_run(0);
    push_exp(0, ST2);
    pulse(0, ST2);
    for (int i = 0; i < 2000 && !(a_wv && a_wl == 2'd2 && a_wa == 11'd300); i++) @(negedge clk);
    check("reach_l2_a300", a_wv && a_wl == 2'd2 && a_wa == 11'd300, $sformatf("wv=%0b l=%0h a=%0d, want 1 2 300", a_wv, a_wl, a_wa));
    #2 rst_n = 0;
    #1;
    check("async_reset", a_zero(), $sformatf("busy=%0b rd=%0b wv=%0b w=%h, want all 0", a_busy, a_rd, a_wv, a_w));
    qa.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    push_exp(0, ST1);
    pulse(0, ST1);
    finish_run(0);
    push_exp(1, 64'h00000000_40490FDB);
    pulse(1, 64'h00000000_40490FDB);
    finish_run(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, want completion");
    $fatal(1);
  end
endmodule
